// File: rtl/boot_pkg.sv
// Shared types and constants for the warmboot controller slice.
package boot_pkg;

  // FSM state codes; the numeric values are visible on the debug state port
  typedef enum logic [1:0] {
    COUNTDOWN = 2'd0,
    HALTED    = 2'd1,
    ARM       = 2'd2,
    BOOT      = 2'd3
  } state_t;

  // Warmboot image index as seen by SB_WARMBOOT {S1,S0}
  typedef logic [1:0] image_t;

  localparam image_t IMAGE_MAX = 2'd3;

endpackage

// File: rtl/warmboot_ctrl_if.sv
// Boot-command handshake between a host-side command source and the controller.
interface warmboot_ctrl_if;
  import boot_pkg::*;

  logic   cmd_valid;
  logic   cmd_ready;
  image_t cmd_image;
  logic   cmd_rearm;

  modport master (
    output cmd_valid,
    output cmd_image,
    output cmd_rearm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_image,
    input  cmd_rearm,
    output cmd_ready
  );

endinterface

// File: rtl/led_progress.sv
// Progress-bar comparator array: led i lights once ctr passes i equal steps of MAX.
module led_progress #(
  parameter int MAX      = 2**27,
  parameter int NUM_LEDS = 8
) (
  input  logic [$clog2(MAX+1)-1:0] ctr,
  output logic [NUM_LEDS-1:0]      leds
);

  localparam int STEP = MAX / NUM_LEDS;

  // One unsigned threshold compare per led, thresholds spaced by STEP
  always_comb begin
    leds = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      leds[i] = (32'(ctr) > 32'(STEP * i));
    end
  end

endmodule

// File: rtl/warmboot_ctrl.sv
// Warmboot controller: counts down to an automatic boot of the selected image,
// lets host traffic halt the countdown, and accepts boot/rearm commands.
module warmboot_ctrl
  import boot_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2**27,
  parameter int NUM_LEDS       = 8,
  parameter int DEFAULT_IMAGE  = 1,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                sresetn,
  input  logic                activity,
  warmboot_ctrl_if.slave      cmd,
  output image_t              sel,
  output logic                boot,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CTR_LAST    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam image_t        RESET_IMAGE = image_t'(DEFAULT_IMAGE);

  state_t              cur_state;
  logic [CW-1:0]       ctr;
  logic [SW-1:0]       settle;
  image_t              target;
  logic [NUM_LEDS-1:0] bar;
  logic                xfer;

  led_progress #(
    .MAX      (TIMEOUT_CYCLES),
    .NUM_LEDS (NUM_LEDS)
  ) u_led_progress (
    .ctr  (ctr),
    .leds (bar)
  );

  assign cmd.cmd_ready = (cur_state == COUNTDOWN) || (cur_state == HALTED);
  assign xfer          = cmd.cmd_valid && cmd.cmd_ready;
  assign state         = cur_state;

  // Main FSM with all registered outputs; a command beats activity, activity beats timeout
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      cur_state <= COUNTDOWN;
      ctr       <= '0;
      settle    <= '0;
      target    <= RESET_IMAGE;
      sel       <= RESET_IMAGE;
      boot      <= 1'b0;
      leds      <= '0;
    end else begin
      if (xfer) begin
        target <= cmd.cmd_image;
        sel    <= cmd.cmd_image;
        if (cmd.cmd_rearm) begin
          ctr       <= '0;
          cur_state <= COUNTDOWN;
        end else begin
          settle    <= '0;
          cur_state <= ARM;
        end
      end else begin
        case (cur_state)
          COUNTDOWN: begin
            if (activity) begin
              cur_state <= HALTED;
            end else begin
              ctr <= ctr + 1'b1;
              if (ctr == CTR_LAST) begin
                settle    <= '0;
                cur_state <= ARM;
              end
            end
          end
          HALTED: begin
            cur_state <= HALTED;
          end
          ARM: begin
            if (settle == SETTLE_LAST) begin
              boot      <= 1'b1;
              cur_state <= BOOT;
            end else begin
              settle <= settle + 1'b1;
            end
          end
          BOOT: begin
            boot <= 1'b1;
          end
          default: begin
            cur_state <= COUNTDOWN;
          end
        endcase
      end

      case (cur_state)
        COUNTDOWN: leds <= bar;
        HALTED:    leds <= '0;
        default:   leds <= '1;
      endcase
    end
  end

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Directed testbench for warmboot_ctrl with hand-computed expectations.
module tb_warmboot_ctrl;
  import boot_pkg::*;

  logic       clk;
  logic       sresetn;
  logic       activity;
  image_t     sel;
  logic       boot;
  logic [7:0] leds;
  logic [1:0] state;
  int         checks;
  int         errors;
  int         cyc;

  warmboot_ctrl_if cmd_if ();

  warmboot_ctrl #(
    .TIMEOUT_CYCLES (64),
    .NUM_LEDS       (8),
    .DEFAULT_IMAGE  (1),
    .SETTLE_CYCLES  (4)
  ) dut (
    .clk      (clk),
    .sresetn  (sresetn),
    .activity (activity),
    .cmd      (cmd_if),
    .sel      (sel),
    .boot     (boot),
    .leds     (leds),
    .state    (state)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and tally the result
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d",
               tag, observed, expected, cyc);
    end
  endtask

  // Drive all non-reset inputs for the coming clock edge
  task automatic applyStimulus(input logic act, input logic valid,
                               input logic [1:0] img, input logic rearm);
    activity         = act;
    cmd_if.cmd_valid = valid;
    cmd_if.cmd_image = img;
    cmd_if.cmd_rearm = rearm;
  endtask

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Two reset edges, then release; the current cycle becomes cycle 0
  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    sresetn = 1'b0;
    tick();
    tick();
    sresetn = 1'b1;
    cyc = 0;
  endtask

  // Expected progress bar for a 64-cycle timeout over 8 leds
  function automatic logic [7:0] bar8(input int c);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = (c > 8 * i);
    return b;
  endfunction

  // Expected state k cycles after the counter started from 0
  function automatic logic [1:0] expState(input int k);
    if (k < 64) return COUNTDOWN;
    if (k < 68) return ARM;
    return BOOT;
  endfunction

  // Expected leds k cycles after the counter started; bar lags ctr by one cycle
  function automatic logic [7:0] expLeds(input int k);
    if (k == 0) return 8'h00;
    if (k <= 64) return bar8(k - 1);
    return 8'hFF;
  endfunction

  // Scenario sequence
  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    sresetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);

    // Outputs while reset is held
    tick();
    tick();
    checkOutput("rst_state", 32'(state), 32'(COUNTDOWN));
    checkOutput("rst_sel", 32'(sel), 32'd1);
    checkOutput("rst_boot", 32'(boot), 32'd0);
    checkOutput("rst_leds", 32'(leds), 32'd0);
    checkOutput("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // Idle auto-boot: ARM at 64, BOOT at 68
    $display("[TB] idle countdown");
    doReset();
    for (int n = 0; n <= 72; n++) begin
      checkOutput($sformatf("idle_state_%0d", n), 32'(state), 32'(expState(n)));
      checkOutput($sformatf("idle_boot_%0d", n), 32'(boot), 32'(n >= 68));
      checkOutput($sformatf("idle_sel_%0d", n), 32'(sel), 32'd1);
      checkOutput($sformatf("idle_leds_%0d", n), 32'(leds), 32'(expLeds(n)));
      checkOutput($sformatf("idle_ready_%0d", n), 32'(cmd_if.cmd_ready), 32'(n < 64));
      tick();
    end

    // Activity at cycle 20 halts the countdown
    $display("[TB] activity halt");
    doReset();
    repeat (20) tick();
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    checkOutput("halt_state", 32'(state), 32'(HALTED));
    checkOutput("halt_leds_lag", 32'(leds), 32'h07);
    checkOutput("halt_ready", 32'(cmd_if.cmd_ready), 32'd1);
    tick();
    checkOutput("halt_leds", 32'(leds), 32'h00);
    for (int n = 0; n < 1000; n++) begin
      if (n == 500) applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
      if (n == 501) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
      tick();
      checkOutput($sformatf("halt_boot_%0d", n), 32'(boot), 32'd0);
    end
    checkOutput("halt_state_end", 32'(state), 32'(HALTED));
    checkOutput("halt_ready_end", 32'(cmd_if.cmd_ready), 32'd1);
    checkOutput("halt_leds_end", 32'(leds), 32'h00);

    // Boot command from HALTED: image 2, four ARM cycles, then BOOT
    $display("[TB] boot command from halted");
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    checkOutput("cmd_arm_state", 32'(state), 32'(ARM));
    checkOutput("cmd_arm_sel", 32'(sel), 32'd2);
    checkOutput("cmd_arm_boot", 32'(boot), 32'd0);
    checkOutput("cmd_arm_ready", 32'(cmd_if.cmd_ready), 32'd0);
    checkOutput("cmd_arm_leds", 32'(leds), 32'h00);
    for (int k = 2; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("cmd_arm%0d_state", k), 32'(state), 32'(ARM));
      checkOutput($sformatf("cmd_arm%0d_boot", k), 32'(boot), 32'd0);
      checkOutput($sformatf("cmd_arm%0d_leds", k), 32'(leds), 32'hFF);
    end
    tick();
    checkOutput("cmd_boot_state", 32'(state), 32'(BOOT));
    checkOutput("cmd_boot_boot", 32'(boot), 32'd1);
    checkOutput("cmd_boot_sel", 32'(sel), 32'd2);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    checkOutput("boot_hold_state", 32'(state), 32'(BOOT));
    checkOutput("boot_hold_boot", 32'(boot), 32'd1);
    checkOutput("boot_hold_sel", 32'(sel), 32'd2);

    // Rearm with image 3 at cycle 30, activity in the same cycle
    $display("[TB] rearm with coincident activity");
    doReset();
    repeat (30) tick();
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    checkOutput("rearm_state", 32'(state), 32'(COUNTDOWN));
    checkOutput("rearm_sel", 32'(sel), 32'd3);
    checkOutput("rearm_leds_lag", 32'(leds), 32'h0F);
    for (int n = 32; n <= 101; n++) begin
      tick();
      checkOutput($sformatf("rearm_state_%0d", n), 32'(state), 32'(expState(n - 31)));
      checkOutput($sformatf("rearm_boot_%0d", n), 32'(boot), 32'(n >= 99));
      checkOutput($sformatf("rearm_leds_%0d", n), 32'(leds), 32'(expLeds(n - 31)));
    end
    checkOutput("rearm_sel_end", 32'(sel), 32'd3);

    // Reset during ARM, then during BOOT
    $display("[TB] reset during arm and boot");
    doReset();
    repeat (5) tick();
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    checkOutput("rarm_pre_state", 32'(state), 32'(ARM));
    checkOutput("rarm_pre_sel", 32'(sel), 32'd2);
    sresetn = 1'b0;
    tick();
    checkOutput("rarm_state", 32'(state), 32'(COUNTDOWN));
    checkOutput("rarm_sel", 32'(sel), 32'd1);
    checkOutput("rarm_boot", 32'(boot), 32'd0);
    checkOutput("rarm_leds", 32'(leds), 32'h00);
    checkOutput("rarm_ready", 32'(cmd_if.cmd_ready), 32'd1);
    sresetn = 1'b1;
    cyc = 0;
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    repeat (4) tick();
    checkOutput("rboot_pre_state", 32'(state), 32'(BOOT));
    checkOutput("rboot_pre_boot", 32'(boot), 32'd1);
    checkOutput("rboot_pre_sel", 32'(sel), 32'd0);
    sresetn = 1'b0;
    tick();
    checkOutput("rboot_state", 32'(state), 32'(COUNTDOWN));
    checkOutput("rboot_boot", 32'(boot), 32'd0);
    checkOutput("rboot_sel", 32'(sel), 32'd1);
    checkOutput("rboot_leds", 32'(leds), 32'h00);
    sresetn = 1'b1;
    cyc = 0;
    repeat (9) tick();
    checkOutput("restart_leds_9", 32'(leds), 32'(bar8(8)));
    checkOutput("restart_state_9", 32'(state), 32'(COUNTDOWN));
    repeat (54) tick();
    checkOutput("restart_state_63", 32'(state), 32'(COUNTDOWN));
    tick();
    checkOutput("restart_state_64", 32'(state), 32'(ARM));
    checkOutput("restart_boot_64", 32'(boot), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/warmboot_ctrl.md
WARMBOOT_CTRL -- requirements
Module: warmboot_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2**27; clock cycles from reset to automatic boot; SHALL be >= NUM_LEDS.
REQ-002 Parameter NUM_LEDS, default 8; width of the progress-bar output.
REQ-003 Parameter DEFAULT_IMAGE, default 1; warmboot image index (0..3) used on reset.
REQ-004 Parameter SETTLE_CYCLES, default 4; cycles that sel is held stable before boot asserts; SHALL be >= 1.
REQ-005 clk  input  1  clock.
REQ-006 sresetn  input  1  reset, synchronous, active-low.
REQ-007 activity  input  1  single-cycle pulse on host traffic (e.g. UART byte received); cancels the auto-boot.
REQ-008 cmd_valid  input  1  boot-command handshake valid.
REQ-009 cmd_ready  output  1  boot-command handshake ready.
REQ-010 cmd_image  input  2  requested image index.
REQ-011 cmd_rearm  input  1  1 = restart the countdown with cmd_image as the new target; 0 = boot immediately.
REQ-012 sel  output  2  image select, wired to SB_WARMBOOT {S1,S0}.
REQ-013 boot  output  1  wired to SB_WARMBOOT BOOT.
REQ-014 leds  output  NUM_LEDS  countdown progress bar.
REQ-015 state  output  2  current FSM state code, for debug.

Function
REQ-016 FSM states: COUNTDOWN=0, HALTED=1, ARM=2, BOOT=3.
REQ-017 COUNTDOWN: ctr increments by 1 per cycle, starting at 0; at ctr==TIMEOUT_CYCLES-1, the next state is ARM.
REQ-018 ctr width is $clog2(TIMEOUT_CYCLES+1); ctr never wraps.
REQ-019 activity in COUNTDOWN moves the FSM to HALTED next cycle; ctr freezes.
REQ-020 activity coincident with the timeout cycle: activity wins and the FSM goes to HALTED.
REQ-021 activity in HALTED, ARM or BOOT has no effect.
REQ-022 cmd_ready is 1 only in COUNTDOWN and HALTED; a transfer occurs when cmd_valid && cmd_ready.
REQ-023 A transfer with cmd_rearm=0 latches cmd_image into target and moves to ARM next cycle.
REQ-024 A transfer with cmd_rearm=1 latches target, clears ctr to 0, and moves to COUNTDOWN.
REQ-025 A transfer coincident with activity: the command wins and activity is ignored.
REQ-026 ARM: a settle counter runs SETTLE_CYCLES cycles, then the FSM moves to BOOT; boot=0 while in ARM.
REQ-027 sel is a register equal to target in every state; target changes only on a command transfer or on reset.
REQ-028 BOOT is terminal: boot=1 and sel is held stable until reset.
REQ-029 leds[i] (registered) is 1 iff state==COUNTDOWN and ctr > (TIMEOUT_CYCLES/NUM_LEDS)*i, with integer division.
REQ-030 leds is all ones in ARM and BOOT, and all zeros in HALTED.
REQ-031 leds lags ctr by exactly one cycle.
REQ-032 All outputs are registered, except cmd_ready and state, which decode directly from the state register.

Reset
REQ-033 When sresetn=0 at a clk edge: state=COUNTDOWN, ctr=0, settle counter=0, target=DEFAULT_IMAGE, sel=DEFAULT_IMAGE, boot=0, leds=0.
REQ-034 Reset asserted in any state, including ARM or BOOT, SHALL abort the operation and restart the countdown.
REQ-035 Following reset release, cmd_ready=1 from the first cycle.

Structure
REQ-036 Package boot_pkg SHALL hold the state enum, the image-index typedef (2 bits) and the IMAGE_MAX constant (3).
REQ-037 The progress-bar comparator array SHALL be a sub-module named led_progress, with parameters MAX and NUM_LEDS, input ctr and output leds.
REQ-038 No SB_WARMBOOT instance inside the block; the top level instantiates it.

Verification
REQ-039 Use TIMEOUT_CYCLES=64, NUM_LEDS=8, SETTLE_CYCLES=4, DEFAULT_IMAGE=1 for all scenarios below.
REQ-040 Idle after reset: sel=1 throughout; leds[7:0] fill progressively (leds[7]=1 at ctr>56); ARM at cycle 64; boot=1 at cycle 68 and held.
REQ-041 activity pulse at cycle 20: state=HALTED, leds=0, boot stays 0 for 1000 cycles, cmd_ready=1.
REQ-042 In HALTED, command (image=2, rearm=0): sel=2 next cycle, 4 ARM cycles, then boot=1 with sel=2.
REQ-043 Command (image=3, rearm=1) at cycle 30, with activity in the same cycle: ctr restarts at 0, state=COUNTDOWN, boot asserts 64+4 cycles later with sel=3.
REQ-044 Reset pulse during ARM, then during BOOT: boot drops, sel=1, ctr=0, countdown restarts.
